metronomo_prog: RTL and testbench
=================================

METRONOMO_PROG -- requirements
Module: metronomo_prog

Interface
REQ-001 Parameter WIDTH, default 4: number of LEDs and maximum beats per measure, at least 2.
REQ-002 Parameter DIV_W, default 16: width of the beat-period input and internal period counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run request; 1 = metronome running, 0 = stopped.
REQ-006 period  input  DIV_W  clock cycles per beat.
REQ-007 beats  input  $clog2(WIDTH+1)  beats per measure.
REQ-008 rev  input  1  0 = LEDs sweep upward from bit 0; 1 = LEDs sweep downward from bit beats-1.
REQ-009 leds  output  WIDTH  registered one-hot indication of the current beat.
REQ-010 beat  output  1  registered one-cycle pulse on every beat.
REQ-011 accent  output  1  registered one-cycle pulse on the first beat of every measure, only ever coincident with beat.

Function
REQ-012 Two-state FSM: IDLE (stopped) and RUN.
REQ-013 IDLE holds leds = 1 (bit 0), beat = 0, accent = 0, period counter = 0, beat index = 0.
REQ-014 IDLE with en = 1 at an edge: next state RUN; at that same edge beat = 1, accent = 1, beat index = 0, and period/beats/rev are latched.
REQ-015 RUN: period counter increments each cycle; when it equals latched period-1 it returns to 0 and a beat occurs at that edge.
REQ-016 Beats are therefore spaced exactly P cycles apart, P = latched period; period = 0 is treated as 1 (a beat every cycle).
REQ-017 On each beat the index advances by 1 and wraps from B-1 to 0, B = latched beats; beats = 0 or beats > WIDTH is treated as WIDTH.
REQ-018 accent = 1 exactly on beats where the new index is 0.
REQ-019 leds = one-hot of index when rev = 0, or of B-1-index when rev = 1, updated at the same edge as beat.
REQ-020 period, beats and rev are re-latched only at beat edges; mid-beat input changes take effect from the following beat.
REQ-021 A shrink of beats that leaves the index >= new B forces the next index to 0 (an accented beat).
REQ-022 RUN with en = 0 at an edge: next state IDLE; outputs take the REQ-013 values at that edge, with no beat pulse.
REQ-023 If en drops on an edge that would otherwise be a beat, stop wins: no beat is issued.
REQ-024 The period counter never exceeds 2^DIV_W - 1; period = 2^DIV_W - 1 is a legal maximum.

Reset
REQ-025 rst = 1 at an edge forces IDLE and all REQ-013 values, overriding en, regardless of state.
REQ-026 After reset deasserts, a stopped-to-running transition requires en = 1 sampled at a later edge.

Structure
REQ-027 Package metronomo_pkg holds the FSM state enum (IDLE, RUN) and a function mapping beats input to effective B.
REQ-028 Sub-module metronomo_tick (period counter with tick output, clear, and period latch) is instantiated once; the FSM, beat index and LED encoding live in the top.
REQ-029 No combinational path from any input to any output.

Verification (WIDTH = 4, DIV_W = 8 unless stated)
REQ-030 Reset with en = 1 held -> leds = 0001, beat = accent = 0 at every edge while rst = 1.
REQ-031 period = 3, beats = 4, rev = 0, en rises -> beats at cycles 0,3,6,9,12; leds 0001,0010,0100,1000,0001; accent at cycles 0 and 12.
REQ-032 period = 2, beats = 3, rev = 1 -> leds 0100,0010,0001,0100; accent every 3rd beat (every 6 cycles).
REQ-033 period = 0, beats = 0 -> beat every cycle, leds rotate through all 4 bits, accent every 4 cycles.
REQ-034 Running with period = 3, change to period = 5 one cycle after a beat -> next beat still 3 cycles after the previous one, then 5-cycle spacing.
REQ-035 en dropped on a beat edge and rst pulsed mid-beat -> no beat pulse, leds = 0001; re-enable yields an immediate accented beat.

Source files
------------

// File: rtl/metronomo_pkg.sv
// rtl/metronomo_pkg.sv - shared FSM state type and beats-per-measure mapping
package metronomo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Zero or out-of-range beat counts fall back to the full LED width
  function automatic int unsigned eff_beats(input int unsigned b, input int unsigned width);
    return ((b == 0) || (b > width)) ? width : b;
  endfunction

endpackage

// File: rtl/metronomo_tick.sv
// rtl/metronomo_tick.sv - beat period counter with latched period and tick output
module metronomo_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_run,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_per;

  // Counter never passes r_per-1, so the maximum period cannot overflow it
  assign o_tick = (r_cnt == (r_per - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_per <= DIV_W'(1);
    end else begin
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_run) begin
        r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
      end
      if (i_load) begin
        r_per <= (i_period == '0) ? DIV_W'(1) : i_period;
      end
    end
  end

endmodule

// File: rtl/metronomo_prog.sv
// rtl/metronomo_prog.sv - programmable metronome with one-hot LED sweep and accent
module metronomo_prog
  import metronomo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [DIV_W-1:0]           period,
  input  logic [$clog2(WIDTH+1)-1:0] beats,
  input  logic                       rev,
  output logic [WIDTH-1:0]           leds,
  output logic                       beat,
  output logic                       accent
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           r_state, w_state_n;
  logic [BW-1:0]    r_idx, w_idx_n;
  logic [WIDTH-1:0] r_leds, w_leds_n;
  logic             r_beat, w_beat_n;
  logic             r_accent, w_accent_n;
  logic [BW-1:0]    w_newb, w_inc, w_pos;
  logic             w_clear, w_run, w_load, w_tick;

  metronomo_tick #(.DIV_W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .i_load   (w_load),
    .i_period (period),
    .o_tick   (w_tick)
  );

  // beats/rev only matter at beat edges, so they are consumed where sampled
  assign w_newb = BW'(eff_beats(32'(beats), WIDTH));
  assign w_inc  = r_idx + 1'b1;

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_leds_n   = r_leds;
    w_beat_n   = 1'b0;
    w_accent_n = 1'b0;
    w_clear    = 1'b0;
    w_run      = 1'b0;
    w_load     = 1'b0;
    w_pos      = '0;
    unique case (r_state)
      IDLE: begin
        w_clear  = 1'b1;
        w_idx_n  = '0;
        w_leds_n = WIDTH'(1);
        if (en) begin
          w_state_n  = RUN;
          w_load     = 1'b1;
          w_beat_n   = 1'b1;
          w_accent_n = 1'b1;
          w_pos      = rev ? (w_newb - 1'b1) : '0;
          w_leds_n   = WIDTH'(1) << w_pos;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_n = IDLE;
          w_clear   = 1'b1;
          w_idx_n   = '0;
          w_leds_n  = WIDTH'(1);
        end else begin
          w_run = 1'b1;
          if (w_tick) begin
            w_load     = 1'b1;
            // Wrap also catches a shrink of beats below the current index
            w_idx_n    = (w_inc >= w_newb) ? '0 : w_inc;
            w_pos      = rev ? (w_newb - 1'b1 - w_idx_n) : w_idx_n;
            w_leds_n   = WIDTH'(1) << w_pos;
            w_beat_n   = 1'b1;
            w_accent_n = (w_idx_n == '0);
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_leds   <= WIDTH'(1);
      r_beat   <= 1'b0;
      r_accent <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_leds   <= w_leds_n;
      r_beat   <= w_beat_n;
      r_accent <= w_accent_n;
    end
  end

  assign leds   = r_leds;
  assign beat   = r_beat;
  assign accent = r_accent;

endmodule

// File: tb/tb_metronomo_prog.sv
// tb/tb_metronomo_prog.sv - directed scoreboard bench for metronomo_prog
module tb_metronomo_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] period;
  logic [2:0] beats;
  logic       rev;
  logic [3:0] leds;
  logic       beat;
  logic       accent;

  int errors = 0;
  int checks = 0;

  logic [5:0] sb_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  metronomo_prog #(.WIDTH(4), .DIV_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (period),
    .beats  (beats),
    .rev    (rev),
    .leds   (leds),
    .beat   (beat),
    .accent (accent)
  );

  function automatic logic [5:0] mk(input int pos, input bit b, input bit a);
    logic [3:0] l;
    l = 4'b0001 << pos;
    return {l, b, a};
  endfunction

  task automatic cyc(input string tag, input logic e, input logic [7:0] p,
                     input logic [2:0] b, input logic r, input logic rs,
                     input logic [5:0] expv);
    logic [5:0] obs;
    logic [5:0] want;
    string      t;
    rst    = rs;
    en     = e;
    period = p;
    beats  = b;
    rev    = r;
    sb_q.push_back(expv);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs  = {leds, beat, accent};
    want = sb_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed leds/beat/accent=%b required=%b", t, obs, want);
    end
  endtask

  initial begin
    int idx;
    bit bt;

    for (int c = 0; c < 3; c++) cyc("reset_en_high", 1, 3, 4, 0, 1, mk(0, 0, 0));

    for (int c = 0; c <= 12; c++) begin
      idx = (c / 3) % 4;
      bt  = (c % 3 == 0);
      cyc("p3_b4_up", 1, 3, 4, 0, 0, mk(idx, bt, bt && idx == 0));
    end
    cyc("stop_after_up", 0, 3, 4, 0, 0, mk(0, 0, 0));
    cyc("idle_hold", 0, 3, 4, 0, 0, mk(0, 0, 0));

    for (int c = 0; c <= 12; c++) begin
      idx = (c / 2) % 3;
      bt  = (c % 2 == 0);
      cyc("p2_b3_rev", 1, 2, 3, 1, 0, mk(2 - idx, bt, bt && idx == 0));
    end
    cyc("stop_after_rev", 0, 2, 3, 1, 0, mk(0, 0, 0));

    for (int c = 0; c <= 8; c++)
      cyc("p0_b0_every", 1, 0, 0, 0, 0, mk(c % 4, 1, c % 4 == 0));
    cyc("stop_after_p0", 0, 0, 0, 0, 0, mk(0, 0, 0));

    // beats=5 exceeds WIDTH and acts as 4; shrinking to 2 at index 1 wraps to an accent
    cyc("shrink_c0", 1, 1, 5, 0, 0, mk(0, 1, 1));
    cyc("shrink_c1", 1, 1, 5, 0, 0, mk(1, 1, 0));
    cyc("shrink_c2", 1, 1, 2, 0, 0, mk(0, 1, 1));
    cyc("shrink_c3", 1, 1, 2, 0, 0, mk(1, 1, 0));
    cyc("shrink_c4", 1, 1, 2, 0, 0, mk(0, 1, 1));
    cyc("stop_after_shrink", 0, 1, 2, 0, 0, mk(0, 0, 0));

    idx = 0;
    for (int c = 0; c <= 17; c++) begin
      bt = (c == 0) || (c == 3) || (c == 8) || (c == 13);
      if (bt && c != 0) idx++;
      cyc("period_change", 1, (c == 0) ? 8'd3 : 8'd5, 4, 0, 0, mk(idx, bt, c == 0));
    end
    cyc("stop_on_beat_edge", 0, 5, 4, 0, 0, mk(0, 0, 0));
    cyc("idle_after_stop", 0, 5, 4, 0, 0, mk(0, 0, 0));

    cyc("rev_b2_start", 1, 4, 2, 1, 0, mk(1, 1, 1));
    cyc("rev_b2_hold", 1, 4, 2, 1, 0, mk(1, 0, 0));
    cyc("rst_mid_beat", 1, 4, 2, 1, 1, mk(0, 0, 0));
    cyc("reenable_accent", 1, 4, 2, 1, 0, mk(1, 1, 1));
    cyc("reenable_hold1", 1, 4, 2, 1, 0, mk(1, 0, 0));
    cyc("reenable_hold2", 1, 4, 2, 1, 0, mk(1, 0, 0));
    cyc("reenable_hold3", 1, 4, 2, 1, 0, mk(1, 0, 0));
    cyc("reenable_beat2", 1, 4, 2, 1, 0, mk(0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
